// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the core
// and the host/debug port.
package dm_arb_pkg;

    localparam int DM_ADDR_W   = 4;
    localparam int DM_DATA_W   = 4;
    localparam int DM_MAX_WAIT = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        HOLD,
        XFER,
        DONE
    } arb_state_e;

    function automatic int wait_cnt_w(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/dm_arb_mux.sv
// Memory-port mux: the core drives the data memory unless the host holds
// the grant for this cycle.
module dm_arb_mux
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
) (
    input  logic              host_grant,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren
);

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wren  = cpu_wren;
        if (host_grant) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_wren  = host_we;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: core has priority, host transfers fill idle core
// cycles, and a starved host forces a one-slot core freeze.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W   = DM_ADDR_W,
    parameter int DATA_W   = DM_DATA_W,
    parameter int MAX_WAIT = DM_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wren,
    input  logic              cpu_rden,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              host_grant,
    output logic              collision
);

    localparam int CNT_W = wait_cnt_w(MAX_WAIT);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              lat_we_q, lat_we_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic              host_ack_q, host_ack_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              collision_q, collision_d;
    logic              cpu_busy;

    assign cpu_busy = cpu_wren | cpu_rden;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        host_rdata_d = host_rdata_q;
        collision_d  = collision_q;
        host_grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (host_req) begin
                    lat_we_d    = host_we;
                    lat_addr_d  = host_addr;
                    lat_wdata_d = host_wdata;
                    wait_cnt_d  = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (!cpu_busy) begin
                    host_grant = 1'b1;
                    state_d    = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) state_d = HOLD;
                end
            end
            HOLD: state_d = XFER;
            XFER: begin
                // Forced slot: the host wins even if the core ignored the hold.
                host_grant = 1'b1;
                state_d    = DONE;
                if (cpu_busy) collision_d = 1'b1;
            end
            DONE: begin
                if (!host_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (host_grant && !lat_we_q) host_rdata_d = mem_q;
        cpu_hold_d = (state_d == HOLD) || (state_d == XFER);
        host_ack_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
            cpu_hold_q   <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            lat_we_q     <= lat_we_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            cpu_hold_q   <= cpu_hold_d;
            collision_q  <= collision_d;
        end
    end

    dm_arb_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mux (
        .host_grant(host_grant),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wren  (cpu_wren),
        .host_addr (lat_addr_q),
        .host_wdata(lat_wdata_q),
        .host_we   (lat_we_q),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren)
    );

    assign cpu_rdata  = mem_q;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign collision  = collision_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized host/core traffic
// checked every cycle against a cycle-count based transaction model.
module tb_dm_arbiter;

    localparam int MW = 8;

    logic       clk, reset;
    logic [3:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_wren, cpu_rden;
    logic       host_req, host_we, host_ack, cpu_hold, host_grant, collision;
    logic [3:0] host_addr, host_wdata, host_rdata;
    logic [3:0] mem_addr, mem_wdata, mem_q;
    logic       mem_wren;

    dm_arbiter #(.ADDR_W(4), .DATA_W(4), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wren(cpu_wren),
        .cpu_rden(cpu_rden), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .cpu_hold(cpu_hold), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .mem_q(mem_q), .host_grant(host_grant),
        .collision(collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] init_val(input int i);
        return (i == 12) ? 4'h3 : 4'((i * 5 + 1) & 15);
    endfunction

    // Physical 16x4 data memory: async read, write on rising edge.
    logic [3:0] mem [16];
    logic       mem_loaded = 1'b0;
    assign mem_q = mem[mem_addr];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a request accepted at some edge has "age" 1 in the
    // first cycle after it. It may take any idle core cycle while
    // age <= MW, otherwise age MW+1 is the hold cycle and MW+2 the forced slot.
    logic [3:0] ref_mem [16];
    bit         ref_init = 0;
    bit         m_pend = 0, m_done = 0, m_coll = 0;
    int         m_age = 0;
    logic       m_we = 0;
    logic [3:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    int         grant_cnt = 0, host_wr_cnt = 0, any_wr_cnt = 0;

    always @(negedge clk) begin
        logic       busy, eg, eh, ewr;
        logic [3:0] ea, ed;
        if (!ref_init) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
            ref_init = 1;
        end
        busy = cpu_wren | cpu_rden;
        if (!reset) begin
            chk("rst_ack", host_ack, 0);
            chk("rst_hold", cpu_hold, 0);
            chk("rst_grant", host_grant, 0);
            chk("rst_coll", collision, 0);
            chk("rst_rdata", host_rdata, 0);
            chk("rst_wren", mem_wren, cpu_wren);
            if (cpu_wren) ref_mem[cpu_addr] = cpu_wdata;
            m_pend = 0; m_done = 0; m_coll = 0; m_rdata = 0;
        end else begin
            eh  = m_pend && (m_age > MW);
            eg  = m_pend && ((m_age <= MW && !busy) || m_age == MW + 2);
            ea  = eg ? m_addr : cpu_addr;
            ed  = eg ? m_wdata : cpu_wdata;
            ewr = eg ? m_we : cpu_wren;
            chk("grant", host_grant, eg);
            chk("hold", cpu_hold, eh);
            chk("ack", host_ack, m_done);
            chk("mem_addr", mem_addr, ea);
            chk("mem_wren", mem_wren, ewr);
            chk("mem_wdata", mem_wdata, ed);
            chk("cpu_rdata", cpu_rdata, ref_mem[ea]);
            chk("collision", collision, m_coll);
            if (m_done) chk("host_rdata", host_rdata, m_rdata);
            if (ewr) begin
                ref_mem[ea] = ed;
                any_wr_cnt++;
            end
            if (eg) begin
                grant_cnt++;
                if (m_we) host_wr_cnt++;
                else m_rdata = ref_mem[m_addr];
                if (m_age == MW + 2 && busy) m_coll = 1;
                m_pend = 0;
                m_done = 1;
            end else if (m_pend) begin
                m_age++;
            end else if (m_done) begin
                if (!host_req) m_done = 0;
            end else if (host_req) begin
                m_pend = 1; m_age = 1;
                m_we = host_we; m_addr = host_addr; m_wdata = host_wdata;
            end
        end
    end

    // Core stimulus. mode: 0 idle, 1 reads every cycle, 2 random, 3 manual.
    int mode = 0;
    bit obey = 1;

    task automatic drive_core();
        int r;
        if (mode == 3) return;
        cpu_addr  = 4'($urandom_range(0, 15));
        cpu_wdata = 4'($urandom_range(0, 15));
        cpu_wren  = 1'b0;
        cpu_rden  = 1'b0;
        if (mode == 0) return;
        if (cpu_hold) begin
            if (!obey) cpu_wren = 1'b1;
        end else if (mode == 1) begin
            cpu_rden = 1'b1;
        end else begin
            r = $urandom_range(0, 3);
            cpu_rden = (r == 1);
            cpu_wren = (r == 2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_core();
    endtask

    task automatic do_req(input logic we, input logic [3:0] a, input logic [3:0] d);
        host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
    endtask

    task automatic wait_ack(output int edges);
        edges = 0;
        while (!host_ack && edges < 40) begin
            tick();
            edges++;
        end
        if (!host_ack) chk("ack_timeout", 0, 1);
    endtask

    task automatic release_req();
        int n = 0;
        host_req = 1'b0;
        while (host_ack && n < 10) begin
            tick();
            n++;
        end
        if (host_ack) chk("ack_drop_timeout", 0, 1);
    endtask

    initial begin
        int e, g0, w0, a0, first, hcnt;
        reset = 1'b0;
        cpu_addr = 0; cpu_wdata = 0; cpu_wren = 0; cpu_rden = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        tick(); tick();
        #2 reset = 1'b1;

        // 1: idle core, host write 0xA to 0x5
        tick();
        g0 = grant_cnt; w0 = host_wr_cnt;
        do_req(1'b1, 4'h5, 4'hA);
        wait_ack(e);
        chk("t1_ack_edges", e, 2);
        chk("t1_grants", grant_cnt - g0, 1);
        chk("t1_writes", host_wr_cnt - w0, 1);
        release_req();
        mode = 3;
        tick();
        cpu_addr = 4'h5; cpu_rden = 1'b1;
        #1 chk("t1_cpu_rdata", cpu_rdata, 4'hA);
        tick();
        cpu_rden = 1'b0;
        mode = 0;

        // 2: idle core, host read of preloaded 0xC
        tick();
        a0 = any_wr_cnt;
        do_req(1'b0, 4'hC, 4'h0);
        wait_ack(e);
        chk("t2_ack_edges", e, 2);
        chk("t2_rdata", host_rdata, 4'h3);
        chk("t2_no_wren", any_wr_cnt - a0, 0);
        release_req();

        // 3: busy core, forced slot
        mode = 1;
        tick();
        g0 = grant_cnt; w0 = host_wr_cnt; first = -1; hcnt = 0; e = 0;
        do_req(1'b1, 4'h1, 4'h7);
        while (!host_ack && e < 40) begin
            tick();
            e++;
            if (cpu_hold) begin
                if (first < 0) first = e;
                hcnt++;
            end
        end
        chk("t3_hold_start", first, 9);
        chk("t3_hold_len", hcnt, 2);
        chk("t3_ack_edges", e, MW + 3);
        chk("t3_grants", grant_cnt - g0, 1);
        chk("t3_writes", host_wr_cnt - w0, 1);
        chk("t3_mem1", mem[1], 4'h7);
        chk("t3_coll", collision, 0);
        release_req();

        // 4: core ignores the hold and writes during the forced slot
        obey = 0;
        tick();
        do_req(1'b1, 4'hB, 4'hE);
        wait_ack(e);
        chk("t4_ack_edges", e, MW + 3);
        chk("t4_memB", mem[11], 4'hE);
        chk("t4_coll", collision, 1);
        release_req();
        obey = 1;
        tick(); tick();
        chk("t4_coll_sticky", collision, 1);

        // 5: async reset while in HOLD
        tick();
        do_req(1'b1, 4'h2, 4'hF);
        e = 0;
        while (!cpu_hold && e < 40) begin
            tick();
            e++;
        end
        chk("t5_reached_hold", cpu_hold, 1);
        #2 reset = 1'b0;
        #1;
        chk("t5_hold", cpu_hold, 0);
        chk("t5_ack", host_ack, 0);
        chk("t5_grant", host_grant, 0);
        chk("t5_wren", mem_wren, 0);
        host_req = 1'b0;
        tick(); tick();
        #2 reset = 1'b1;
        chk("t5_mem2", mem[2], init_val(2));
        chk("t5_coll", collision, 0);
        mode = 0;
        tick();
        do_req(1'b1, 4'h2, 4'hF);
        wait_ack(e);
        chk("t5_ack_edges", e, 2);
        release_req();
        chk("t5_mem2_new", mem[2], 4'hF);

        // 6: long req hold, host inputs change mid-transfer
        mode = 1;
        tick();
        g0 = grant_cnt;
        do_req(1'b1, 4'h3, 4'h6);
        tick(); tick();
        host_addr = 4'h4; host_wdata = 4'h9;
        wait_ack(e);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_ack_held", host_ack, 1);
        end
        release_req();
        chk("t6_grants", grant_cnt - g0, 1);
        chk("t6_mem3", mem[3], 4'h6);
        chk("t6_mem4", mem[4], init_val(4));

        // Random traffic
        mode = 2;
        for (int t = 0; t < 150; t++) begin
            bit early;
            repeat ($urandom_range(0, 3)) tick();
            do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)));
            early = ($urandom_range(0, 5) == 0);
            if (early) begin
                tick();
                host_req = 1'b0;
            end
            wait_ack(e);
            if (!early) repeat ($urandom_range(0, 3)) tick();
            release_req();
        end
        tick(); tick();
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Shares the 16x4 data memory between the processor core and an external host/debug port.
- The core always has priority and is never stalled voluntarily.
- Host transfers are scheduled into idle core cycles.
- If the host waits MAX_WAIT cycles without an idle slot, the arbiter asserts cpu_hold to freeze the core for one slot.
- Sits between the core's data-memory signals (address i, data_bus, register_enables[7]) and the data_memory instance.

Parameters:
ADDR_W, 4, data memory address width
DATA_W, 4, data memory word width
MAX_WAIT, 8, host wait cycles before forcing a slot (legal range 1..255)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
cpu_addr  in  ADDR_W  core data-memory address
cpu_wdata  in  DATA_W  core write data
cpu_wren  in  1  core write this cycle
cpu_rden  in  1  core reads dm this cycle
cpu_rdata  out  DATA_W  mem_q passed through to the core (combinational)
host_req  in  1  four-phase request
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_ack  out  1  four-phase acknowledge
host_rdata  out  DATA_W  read result, valid while host_ack=1
cpu_hold  out  1  freeze request to program sequencer and register enables
mem_addr  out  ADDR_W  to data memory
mem_wdata  out  DATA_W  to data memory
mem_wren  out  1  to data memory
mem_q  in  DATA_W  from data memory
host_grant  out  1  host owns memory this cycle (status)
collision  out  1  sticky error flag

Behaviour:
- FSM states: IDLE, WAIT, HOLD, XFER, DONE. cpu_busy = cpu_wren | cpu_rden.
- Reset (reset=0, async): state=IDLE, wait_cnt=0, latched host fields=0, host_ack=0, host_rdata=0, cpu_hold=0, collision=0.
  - Host-driven memory outputs drop immediately on reset. No partial host write is possible.
- IDLE: on host_req=1, latch host_we/addr/wdata, clear wait_cnt, go to WAIT.
  - Later changes to the host inputs are ignored until the next IDLE.
- WAIT:
  - If cpu_busy=0 this cycle: host_grant=1 combinationally, and memory is muxed to the latched host fields in this same cycle. Go to DONE.
  - Else wait_cnt++. When wait_cnt reaches MAX_WAIT-1 with the core still busy, go to HOLD.
- HOLD: cpu_hold=1 (registered), core keeps the memory this cycle; next state XFER.
- XFER:
  - cpu_hold=1 and host_grant=1; host owns memory unconditionally. Next state DONE.
  - If cpu_busy=1 in XFER (core ignored the hold), the host still wins and collision is set sticky until reset.
- Granted cycle:
  - Write: mem_wren=1 for exactly that cycle.
  - Read: host_rdata is captured from mem_q at the closing rising edge.
  - mem_addr comes from the latched host_addr.
- DONE: host_ack=1 (registered), cpu_hold=0. Stay in DONE while host_req=1; go to IDLE when host_req=0.
  - host_ack falls the cycle after host_req falls, so a new request cannot be accepted in the same cycle the previous one is released.
- Non-grant cycles: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_wren=cpu_wren.
- Latency:
  - Idle core: req sampled (edge 0), grant in cycle 1, ack high after edge 2.
  - Forced slot: ack at most MAX_WAIT+3 edges after req.
- Exactly one memory access per handshake. cpu_hold never exceeds 2 consecutive cycles per request.
- host_req dropped before ack (protocol violation): the transfer still completes, then DONE exits on the next cycle.

Decomposition:
- Shared package dm_arb_pkg: state enum (IDLE, WAIT, HOLD, XFER, DONE), ADDR_W/DATA_W constants, wait-counter width = $clog2(MAX_WAIT+1).
- One natural sub-module, dm_arb_mux: purely combinational memory-port mux selected by host_grant.
- FSM and capture registers stay in dm_arbiter.

Test Plan:
1. Core idle (cpu_wren=cpu_rden=0); host write addr=0x5, data=0xA.
   - Required: host_grant=1 and mem_wren=1 in one cycle, host_ack rises 2 edges after req.
   - Subsequent core read of 0x5 gives cpu_rdata=0xA.
2. Memory pre-loaded with 0x3 at addr 0xC, core idle; host read addr=0xC.
   - Required: host_rdata=0x3 while host_ack=1; no mem_wren pulse.
3. Core busy every cycle, MAX_WAIT=8; host write addr=0x1, data=0x7.
   - Required: cpu_hold high for exactly 2 cycles starting 9 edges after req.
   - Single mem_wren in the XFER cycle; mem[1]=0x7; collision stays 0.
4. Same as 3, but the core asserts cpu_wren in the XFER cycle.
   - Required: host write wins (mem[addr]=host data) and collision=1 until reset.
5. Drive reset=0 asynchronously while in HOLD.
   - Required: cpu_hold=0, host_ack=0, state=IDLE immediately; no memory write occurs.
   - After release, a new host request completes normally.
6. Hold host_req high 5 cycles after ack, and change host_addr mid-transfer.
   - Required: host_ack stays high until req falls and only one access occurs.
   - The access uses the address latched at request.
